// File: rtl/neopixel_pkg.sv
// ---------------------------------------------------------------------------
// neopixel_pkg
// Shared definitions for the NeoPixel pixel path: the frame sync marker,
// the pixel word width, the frame-parser state encodings and the GRB byte
// lane layout. The WS2812 output driver uses the same lane constants, so a
// pixel word written by the parser and read by the driver has one layout.
// ---------------------------------------------------------------------------
package neopixel_pkg;

  // Frame start marker on the wire.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Width of one pixel word in pixel memory.
  localparam int PIXEL_W = 24;

  // Frame parser state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEN   = 2'd1;
  localparam logic [1:0] ST_COLOR = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Byte lanes inside a pixel word: {G,R,B}, G in the top byte.
  localparam int GRB_G_LANE = 2;
  localparam int GRB_R_LANE = 1;
  localparam int GRB_B_LANE = 0;

  // Build a pixel word from its three colour bytes.
  function automatic logic [PIXEL_W-1:0] pack_grb(input logic [7:0] g,
                                                   input logic [7:0] r,
                                                   input logic [7:0] b);
    logic [PIXEL_W-1:0] p;
    p = '0;
    p[GRB_G_LANE*8 +: 8] = g;
    p[GRB_R_LANE*8 +: 8] = r;
    p[GRB_B_LANE*8 +: 8] = b;
    return p;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// ---------------------------------------------------------------------------
// byte_timeout
// Inter-byte watchdog. A down-counter that reloads to TIMEOUT_CLKS-1 while
// disabled or whenever a byte strobe arrives, and counts down while enabled.
// o_expired is high for the cycle in which the count sits at zero with no
// byte strobe present; a strobe in that same cycle wins and reloads instead.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous reset, active-high (reloads the counter)
//   i_enable   count only while high (parser is inside a frame)
//   i_clear    byte strobe, reloads the counter
//   o_expired  one-cycle expiry indication
// ---------------------------------------------------------------------------
module byte_timeout #(
  parameter int TIMEOUT_CLKS = 12000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_enable || i_clear) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      // Parks at zero; the parser leaves the frame on expiry, which reloads.
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = i_enable && !i_clear && (r_cnt == '0);

endmodule

// File: rtl/neopixel_frame_parser.sv
// ---------------------------------------------------------------------------
// neopixel_frame_parser
// Consumes the UART receiver's byte stream and parses frames of the form
//   SYNC_BYTE, N, then N pixels of three bytes each in G, R, B order.
// Each completed pixel is written to pixel memory one clock after its B byte.
// A one-cycle frame-done pulse follows the final write. A bad length byte
// (0 or more than MAX_PIXELS) or an inter-byte timeout inside a frame aborts
// the frame with a one-cycle error pulse; pixels already written remain.
//
// Handshake: i_rx_valid is a one-cycle strobe; i_rx_byte is meaningful only
// while it is high. There is no back-pressure: a strobe seen in DONE is
// dropped, which the UART's minimum character spacing makes harmless.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_rx_byte        received byte
//   i_rx_valid       byte strobe
//   o_wr_en          pixel memory write strobe
//   o_wr_addr        pixel index written (held when o_wr_en=0)
//   o_wr_data        pixel word {G,R,B}   (held when o_wr_en=0)
//   o_frame_done     one-cycle pulse, whole frame written
//   o_err            one-cycle pulse, frame aborted
// ---------------------------------------------------------------------------
module neopixel_frame_parser
  import neopixel_pkg::*;
#(
  parameter int         MAX_PIXELS   = 64,
  parameter int         ADDR_W       = 6,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 12000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_byte,
  input  logic               i_rx_valid,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [PIXEL_W-1:0] o_wr_data,
  output logic               o_frame_done,
  output logic               o_err
);

  localparam logic [7:0] MAX_N = 8'(MAX_PIXELS);
  // Common width for comparing the pixel index against the latched length.
  localparam int CMP_W = (ADDR_W > 8) ? ADDR_W : 8;

  logic [1:0]         r_state;
  logic [7:0]         r_len;
  logic [ADDR_W-1:0]  r_pix_idx;
  logic [1:0]         r_byte_cnt;
  logic [15:0]        r_gr;        // G and R bytes of the pixel in flight
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [PIXEL_W-1:0] r_wr_data;
  logic               r_frame_done;
  logic               r_err;

  logic w_timer_en;
  logic w_expired;
  logic w_len_bad;
  logic w_last_pixel;

  assign w_timer_en   = (r_state == ST_LEN) || (r_state == ST_COLOR);
  assign w_len_bad    = (i_rx_byte == 8'd0) || (i_rx_byte > MAX_N);
  assign w_last_pixel = (CMP_W'(r_pix_idx) == (CMP_W'(r_len) - CMP_W'(1)));

  byte_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_byte_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (w_timer_en),
    .i_clear   (i_rx_valid),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_len        <= 8'd0;
      r_pix_idx    <= '0;
      r_byte_cnt   <= 2'd0;
      r_gr         <= 16'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Strobes default low; address/data hold their last value.
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid && (i_rx_byte == SYNC_BYTE)) begin
            r_state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (i_rx_valid) begin
            if (w_len_bad) begin
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
            end else begin
              r_len      <= i_rx_byte;
              r_pix_idx  <= '0;
              r_byte_cnt <= 2'd0;
              r_state    <= ST_COLOR;
            end
          end else if (w_expired) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end
        end

        ST_COLOR: begin
          if (i_rx_valid) begin
            // A sync-valued byte here is ordinary colour data.
            if (r_byte_cnt == 2'd2) begin
              r_byte_cnt <= 2'd0;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= r_pix_idx;
              r_wr_data  <= pack_grb(r_gr[15:8], r_gr[7:0], i_rx_byte);
              r_pix_idx  <= r_pix_idx + ADDR_W'(1);
              if (w_last_pixel) begin
                r_state <= ST_DONE;
              end
            end else begin
              r_gr       <= {r_gr[7:0], i_rx_byte};
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end else if (w_expired) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end
        end

        ST_DONE: begin
          // Any byte strobe in this cycle is dropped.
          r_frame_done <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

endmodule

// File: doc/neopixel_frame_parser.md
Name: neopixel_frame_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (one-cycle valid strobe per byte).
- Parses a framed pixel-update protocol and writes 24-bit GRB pixel words into the pixel memory that the WS2812 output driver reads.
- Pulses frame-done when a complete, well-formed frame has been written.
- Aborts partial frames on protocol error or inter-byte timeout.

Parameters:
- MAX_PIXELS, 64, largest pixel count accepted in a frame (1..255).
- ADDR_W, 6, pixel memory address width; 2**ADDR_W >= MAX_PIXELS.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 12000, maximum clocks between bytes inside a frame (1 ms at 12 MHz).

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_rx_byte  in  8  received byte; valid only when i_rx_valid=1.
- i_rx_valid  in  1  one-cycle strobe, byte available.
- o_wr_en  out  1  one-cycle pixel memory write strobe.
- o_wr_addr  out  ADDR_W  pixel index being written.
- o_wr_data  out  24  pixel word {G,R,B}.
- o_frame_done  out  1  one-cycle pulse, frame fully written.
- o_err  out  1  one-cycle pulse, frame aborted.

Behaviour:
- Wire format: SYNC_BYTE, N (pixel count), then 3*N bytes in G, R, B order per pixel, pixel 0 first.
- Reset (synchronous, i_reset=1 at a clock edge):
  - state=IDLE; pixel index, byte-in-pixel counter and timeout counter cleared.
  - o_wr_en, o_wr_addr, o_wr_data, o_frame_done and o_err all 0.
  - Reset mid-frame discards the frame with no further writes and no o_err.
- States:
  - IDLE: on a valid byte equal to SYNC_BYTE -> LEN; other bytes are ignored silently.
  - LEN: on a valid byte N:
    - N==0 or N>MAX_PIXELS -> IDLE with o_err pulsed the next cycle.
    - Otherwise latch N, clear pixel index and byte counter -> COLOR.
  - COLOR: shift each valid byte into the 24-bit assembly register.
    - On the third byte of a pixel, the next cycle drives o_wr_en=1, o_wr_addr=pixel index, o_wr_data={G,R,B}; the index then increments.
    - When the written index equals N-1 -> DONE.
  - DONE: o_frame_done=1 for exactly one cycle (the cycle after the final o_wr_en) -> IDLE.
- Latency: one clock from the i_rx_valid of a pixel's B byte to the corresponding o_wr_en.
- A SYNC_BYTE value received in LEN or COLOR is treated as ordinary data; there is no resynchronisation mid-frame.
- Timeout:
  - Counter runs only in LEN and COLOR and clears on every i_rx_valid.
  - Reaching TIMEOUT_CLKS-1 -> IDLE with o_err pulsed one cycle.
  - Pixels already written stay written; o_frame_done is not asserted.
  - If i_rx_valid coincides with the terminal count, the byte wins: it is processed and the counter clears.
- i_rx_valid asserted in DONE is ignored, so the byte is dropped. This is legal because the UART cannot produce back-to-back bytes closer than one character time.
- Arithmetic: pixel index is ADDR_W bits and never wraps, since N<=MAX_PIXELS<=2**ADDR_W. The byte counter is 2 bits and counts 0..2.
- o_wr_data and o_wr_addr hold their last value when o_wr_en=0.
- o_frame_done and o_err are never asserted in the same cycle.

Decomposition:
- Shared package neopixel_pkg holds:
  - SYNC_BYTE default;
  - PIXEL_W=24;
  - state encodings IDLE/LEN/COLOR/DONE as 2-bit localparams;
  - GRB byte-order constants, also used by the WS2812 driver.
- One natural sub-module: byte_timeout. It is a loadable down-counter with enable, clear-on-strobe and a one-cycle expiry output, parameterised by TIMEOUT_CLKS.

Test Plan:
- Bytes A5,02,10,20,30,40,50,60 -> writes addr0=0x102030, addr1=0x405060, each one cycle after the B byte; o_frame_done one cycle after the second write; o_err never set.
- Bytes 00,FF then A5,01,11,22,33 -> leading bytes ignored; single write addr0=0x112233 then o_frame_done.
- Bytes A5,00 and A5,41 (MAX_PIXELS=64) -> o_err pulse after each length byte; no writes; parser accepts next valid frame.
- Bytes A5,02,AA,BB,CC,DD, then idle for TIMEOUT_CLKS -> one write addr0=0xAABBCC; o_err pulse at expiry; no o_frame_done; next frame parses from addr0.
- i_reset asserted for one clock between the 2nd and 3rd colour byte of a frame -> all outputs 0, no write; next frame A5,01,01,02,03 writes 0x010203 to addr0.
- Byte arriving exactly on timeout terminal count -> accepted, no o_err, frame completes normally.
